// File: rtl/times_table_sweeper.sv
// -----------------------------------------------------------------------------
// times_table_sweeper
//
// Drives the memory-based 0..7 x 0..7 times-table multiplier through every
// operand pair in row-major order. Each pair is issued with read. The
// returned product is matched back to its operands by a tag pipeline whose
// depth equals the memory latency. The product and its operands are then
// presented downstream, and a running sum acts as a self-check. A full
// sweep sums to 784.
//
// Parameters
//   MEM_LATENCY  cycles from read (with a/b) to mem_result valid, 1..4
//   SUM_WIDTH    width of the running product sum (>= 10)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        one-cycle pulse; begins a sweep when idle
//   pause        level; suppresses new reads while high
//   a, b         operands to the multiplier
//   read         memory read enable to the multiplier
//   mem_result   product returned by the multiplier
//   out_valid    out_a/out_b/out_result valid this cycle
//   out_a/out_b  operands of the presented product
//   out_result   presented product (0 when out_valid is low)
//   sum          running sum of presented products for the current sweep
//   busy         high from accepted start until done
//   done         one-cycle pulse after the final product is presented
// -----------------------------------------------------------------------------
module times_table_sweeper #(
  parameter int MEM_LATENCY = 1,
  parameter int SUM_WIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pause,
  output logic [2:0]           a,
  output logic [2:0]           b,
  output logic                 read,
  input  logic [5:0]           mem_result,
  output logic                 out_valid,
  output logic [2:0]           out_a,
  output logic [2:0]           out_b,
  output logic [5:0]           out_result,
  output logic [SUM_WIDTH-1:0] sum,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One slot of the tag pipeline: the operands travel alongside the read.
  typedef struct packed {
    logic       valid;
    logic [2:0] a;
    logic [2:0] b;
  } tag_t;

  state_t               state_q, state_d;
  logic [2:0]           a_q, a_d;
  logic [2:0]           b_q, b_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  tag_t                 tag_q [MEM_LATENCY];
  tag_t                 tag_d [MEM_LATENCY];

  logic                 issue;
  logic                 drain_empty;
  tag_t                 tag_out;
  logic [SUM_WIDTH-1:0] product_ext;

  // A read goes out in every ISSUE cycle that is not paused.
  assign issue   = (state_q == S_ISSUE) && !pause;
  assign tag_out = tag_q[MEM_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Next-state and operand counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          a_d     = 3'd0;
          b_d     = 3'd0;
        end
      end

      S_ISSUE: begin
        if (issue) begin
          // b is the low digit: it wraps 7->0 and carries into a.
          {a_d, b_d} = {a_q, b_q} + 6'd1;
          if (a_q == 3'd7 && b_q == 3'd7) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (drain_empty) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: stage 0 captures this cycle's read, later stages shift.
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_d[0].valid = issue;
    tag_d[0].a     = a_q;
    tag_d[0].b     = b_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // In DRAIN no new read enters stage 0, and the last stage is presenting
  // this cycle. The pipeline is therefore empty next cycle once every stage
  // ahead of the last holds no valid. Leaving on that condition puts done
  // immediately after the final product.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < MEM_LATENCY - 1; i++) begin
      if (tag_q[i].valid) begin
        drain_empty = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Running sum of presented products
  // ---------------------------------------------------------------------------
  always_comb begin
    product_ext      = '0;
    product_ext[5:0] = out_result;

    sum_d = sum_q;
    if (state_q == S_IDLE && start) begin
      sum_d = '0;
    end else if (tag_out.valid) begin
      sum_d = sum_q + product_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment. Every flop then samples
    // pre-edge values, and the order of these statements has no effect.
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 3'd0;
      b_q     <= 3'd0;
      sum_q   <= '0;
      // NOTE: the tag pipeline is reset, unlike a data-only memory. Its
      // valid bits mark in-flight reads, and clearing them is how a reset
      // discards products still in the multiplier.
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign a          = a_q;
  assign b          = b_q;
  assign read       = issue;
  assign out_valid  = tag_out.valid;
  assign out_a      = tag_out.a;
  assign out_b      = tag_out.b;
  // mem_result is only meaningful alongside a valid tag; gate it otherwise.
  assign out_result = tag_out.valid ? mem_result : 6'd0;
  assign sum        = sum_q;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

endmodule
